adder_operand_sequencer: RTL

//   Upstream control stage for the 6-bit ripple binary adder. Captures operand A, then operand B,

---
 rtl/adder_operand_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/adder_operand_sequencer.sv
// adder_operand_sequencer: loads A then B from switches, waits for the adder to settle, holds the sum.
// Build option: define OVERFLOW_DETECT_EN to register signed overflow on ovf.
module adder_operand_sequencer #(
  parameter int WIDTH         = 6,
  parameter int SETTLE_CYCLES = 2,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             load_btn,
  input  logic             clear_btn,
  input  logic [WIDTH-1:0] sum_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [1:0]       state,
  output logic             ovf
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HAVE_A = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] ld_sync;
  logic [SYNC_STAGES-1:0] clr_sync;
  logic                   ld_q;
  logic                   clr_q;
  logic                   ld_ev;
  logic                   clr_ev;
  logic [CW-1:0]          cnt;
  logic                   settle_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_sync  <= '0;
      clr_sync <= '0;
      ld_q     <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      ld_sync  <= {ld_sync[SYNC_STAGES-2:0], load_btn};
      clr_sync <= {clr_sync[SYNC_STAGES-2:0], clear_btn};
      ld_q     <= ld_sync[SYNC_STAGES-1];
      clr_q    <= clr_sync[SYNC_STAGES-1];
    end
  end

  assign ld_ev       = ld_sync[SYNC_STAGES-1] & ~ld_q;
  assign clr_ev      = clr_sync[SYNC_STAGES-1] & ~clr_q;
  assign settle_done = (state == SETTLE) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      a_out        <= '0;
      b_out        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      cnt          <= '0;
    end else if (clr_ev) begin
      // clear outranks a coincident load
      state        <= IDLE;
      a_out        <= '0;
      b_out        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      cnt          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ld_ev) begin
            a_out <= sw;
            state <= HAVE_A;
          end
        end
        HAVE_A: begin
          if (ld_ev) begin
            b_out <= sw;
            cnt   <= '0;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_done) begin
            result       <= sum_in;
            result_valid <= 1'b1;
            state        <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (ld_ev) begin
            a_out        <= sw;
            result_valid <= 1'b0;
            state        <= HAVE_A;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OVERFLOW_DETECT_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (clr_ev) begin
      ovf_q <= 1'b0;
    end else if (settle_done) begin
      ovf_q <= (a_out[WIDTH-1] == b_out[WIDTH-1]) &&
               (sum_in[WIDTH-1] != a_out[WIDTH-1]);
    end else if (state == DONE && ld_ev) begin
      ovf_q <= 1'b0;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule
